// File: rtl/host_cmd_parser.sv
// Host command frame parser: START, CMD, [ADDR], [PAYLOAD], CHK framing from the UART RX stream,
// with payload streaming, decoded command strobe, ACK/NAK response and error pulses.
module host_cmd_parser #(
    parameter int          ADDR_BYTES     = 4,
    parameter int          PAYLOAD_BYTES  = 4,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  START_BYTE     = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h5A,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [3:0]              host_cmd,
    output logic [8*ADDR_BYTES-1:0] cmd_addr,
    output logic                    cmd_valid,
    output logic [7:0]              pl_data,
    output logic                    pl_valid,
    output logic                    pl_last,
    output logic                    err_chk,
    output logic                    err_timeout,
    output logic                    err_cmd,
    output logic                    busy
);

    localparam int AW  = 8 * ADDR_BYTES;
    localparam int ACW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int PCW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [3:0] CMD_NONE   = 4'd0;
    localparam logic [3:0] CMD_INIT   = 4'd1;
    localparam logic [3:0] CMD_STATUS = 4'd2;
    localparam logic [3:0] CMD_READ   = 4'd3;
    localparam logic [3:0] CMD_WRITE  = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_CMD   = 3'd1,
        S_GET_ADDR  = 3'd2,
        S_GET_DATA  = 3'd3,
        S_GET_CHK   = 3'd4,
        S_SEND_RESP = 3'd5
    } state_t;

    function automatic logic [3:0] decode_cmd(input logic [7:0] b);
        case (b)
            8'h10:   decode_cmd = CMD_INIT;
            8'h50:   decode_cmd = CMD_STATUS;
            8'h20:   decode_cmd = CMD_READ;
            8'h40:   decode_cmd = CMD_WRITE;
            default: decode_cmd = CMD_NONE;
        endcase
    endfunction

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        chk_fold = acc ^ b;
    endfunction

    state_t           state_q;
    logic [3:0]       frame_cmd_q;
    logic [AW-1:0]    addr_q;
    logic [7:0]       chk_q;
    logic [ACW-1:0]   addr_cnt_q;
    logic [PCW-1:0]   pl_cnt_q;
    logic [TW-1:0]    timer_q;

    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic [3:0]       host_cmd_q;
    logic [AW-1:0]    cmd_addr_q;
    logic             cmd_valid_q;
    logic [7:0]       pl_data_q;
    logic             pl_valid_q;
    logic             pl_last_q;
    logic             err_chk_q;
    logic             err_timeout_q;
    logic             err_cmd_q;
    logic             busy_q;

    logic [AW-1:0]    addr_d;
    logic [7:0]       chk_d;
    logic [3:0]       rx_cmd;
    logic             in_frame;
    logic             timer_expired;

    assign addr_d        = (addr_q << 8) | AW'(rx_data);
    assign chk_d         = chk_fold(chk_q, rx_data);
    assign rx_cmd        = decode_cmd(rx_data);
    assign in_frame      = state_q inside {S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK};
    assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM: byte parsing, timeout supervision and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_cmd_q   <= CMD_NONE;
            addr_q        <= '0;
            chk_q         <= 8'h00;
            addr_cnt_q    <= '0;
            pl_cnt_q      <= '0;
            timer_q       <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            host_cmd_q    <= CMD_NONE;
            cmd_addr_q    <= '0;
            cmd_valid_q   <= 1'b0;
            pl_data_q     <= 8'h00;
            pl_valid_q    <= 1'b0;
            pl_last_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cmd_valid_q   <= 1'b0;
            pl_valid_q    <= 1'b0;
            pl_last_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
            timer_q       <= (rx_valid || !in_frame) ? '0 : timer_q + TW'(1);

            // A byte landing on the expiry cycle takes priority over the timeout.
            if (in_frame && !rx_valid && timer_expired) begin
                err_timeout_q <= 1'b1;
                timer_q       <= '0;
                state_q       <= S_IDLE;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid && (rx_data == START_BYTE)) begin
                            addr_q     <= '0;
                            addr_cnt_q <= '0;
                            pl_cnt_q   <= '0;
                            state_q    <= S_GET_CMD;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_GET_CMD: begin
                        if (rx_valid) begin
                            chk_q       <= rx_data;
                            frame_cmd_q <= rx_cmd;
                            case (rx_cmd)
                                CMD_INIT, CMD_STATUS: state_q <= S_GET_CHK;
                                CMD_READ, CMD_WRITE:  state_q <= S_GET_ADDR;
                                default: begin
                                    err_cmd_q  <= 1'b1;
                                    tx_data_q  <= NAK_BYTE;
                                    tx_valid_q <= 1'b1;
                                    state_q    <= S_SEND_RESP;
                                end
                            endcase
                        end
                    end
                    S_GET_ADDR: begin
                        if (rx_valid) begin
                            addr_q <= addr_d;
                            chk_q  <= chk_d;
                            if (addr_cnt_q == ACW'(ADDR_BYTES - 1)) begin
                                state_q <= (frame_cmd_q == CMD_WRITE) ? S_GET_DATA : S_GET_CHK;
                            end else begin
                                addr_cnt_q <= addr_cnt_q + ACW'(1);
                            end
                        end
                    end
                    S_GET_DATA: begin
                        if (rx_valid) begin
                            pl_data_q  <= rx_data;
                            pl_valid_q <= 1'b1;
                            chk_q      <= chk_d;
                            if (pl_cnt_q == PCW'(PAYLOAD_BYTES - 1)) begin
                                pl_last_q <= 1'b1;
                                state_q   <= S_GET_CHK;
                            end else begin
                                pl_cnt_q <= pl_cnt_q + PCW'(1);
                            end
                        end
                    end
                    S_GET_CHK: begin
                        if (rx_valid) begin
                            if (rx_data == chk_q) begin
                                cmd_valid_q <= 1'b1;
                                host_cmd_q  <= frame_cmd_q;
                                cmd_addr_q  <= addr_q;
                                tx_data_q   <= ACK_BYTE;
                            end else begin
                                err_chk_q   <= 1'b1;
                                tx_data_q   <= NAK_BYTE;
                            end
                            tx_valid_q <= 1'b1;
                            state_q    <= S_SEND_RESP;
                        end
                    end
                    S_SEND_RESP: begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_cmd    = host_cmd_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_valid   = cmd_valid_q;
    assign pl_data     = pl_data_q;
    assign pl_valid    = pl_valid_q;
    assign pl_last     = pl_last_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign err_cmd     = err_cmd_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_host_cmd_parser.sv
// Scoreboard bench for host_cmd_parser: frame-level reference model pushes expected events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_host_cmd_parser;

    localparam int AB = 4;
    localparam int PB = 4;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  host_cmd;
    logic [31:0] cmd_addr;
    logic        cmd_valid;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        err_chk;
    logic        err_timeout;
    logic        err_cmd;
    logic        busy;

    host_cmd_parser #(
        .ADDR_BYTES(AB), .PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO),
        .START_BYTE(8'hA5), .ACK_BYTE(8'h5A), .NAK_BYTE(8'hEE)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .host_cmd(host_cmd), .cmd_addr(cmd_addr), .cmd_valid(cmd_valid),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
        .err_chk(err_chk), .err_timeout(err_timeout), .err_cmd(err_cmd), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; logic last; int c; } pl_t;
    typedef struct { logic [3:0] cmd; logic [31:0] addr; int c; } cmd_t;
    typedef struct { int kind; int c; } err_t;   // kind: 1 chk, 2 timeout, 3 cmd

    pl_t        pl_q[$];
    cmd_t       cmd_q[$];
    err_t       err_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cmd_kind(input logic [7:0] b);
        if (b == 8'h10) return 1;
        if (b == 8'h50) return 2;
        if (b == 8'h20) return 3;
        if (b == 8'h40) return 4;
        return 0;
    endfunction

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return TO - 1;
        if (r == 1) return $urandom_range(0, TO - 1);
        return $urandom_range(0, 2);
    endfunction

    // All tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, output int c);
        rx_data  = b;
        rx_valid = 1'b1;
        c = cyc + 1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int g);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin @(posedge clk); #1; k++; end
        if (k >= 3000) check("wait_idle_bound", busy, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tx_data, tx_valid, host_cmd, cmd_addr, cmd_valid, pl_data,
                                pl_valid, pl_last, err_chk, err_timeout, err_cmd, busy}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Reference model: builds the frame, sends it, and queues the events it must produce.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] pl,
                             input logic [7:0] flip, input int stop_after, input int gap_fix,
                             input bit junk, input bit do_wait);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int kind, c, last_c, plo;
        bit stopped;
        pl_t  pe;
        cmd_t ce;
        err_t ee;
        kind = cmd_kind(cmd);
        bytes.push_back(8'hA5);
        bytes.push_back(cmd);
        if (kind != 0) begin
            if (kind >= 3) for (int i = AB - 1; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
            if (kind == 4) for (int i = PB - 1; i >= 0; i--) bytes.push_back(pl[8*i +: 8]);
            x = 8'h00;
            for (int i = 1; i < bytes.size(); i++) x = x ^ bytes[i];
            bytes.push_back(x ^ flip);
        end
        stopped = (stop_after >= 0) && (stop_after < bytes.size() - 1);
        plo = 2 + AB;
        last_c = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            if (stopped && i > stop_after) break;
            if (i > 0) idle((gap_fix < 0) ? pick_gap() : gap_fix);
            send_byte(bytes[i], c);
            last_c = c;
            if (kind == 4 && i >= plo && i < plo + PB) begin
                pe.data = bytes[i]; pe.last = (i == plo + PB - 1); pe.c = c;
                pl_q.push_back(pe);
            end
            if (i == bytes.size() - 1) begin
                if (kind == 0) begin
                    ee.kind = 3; ee.c = c; err_q.push_back(ee);
                    tx_q.push_back(8'hEE);
                end else if (flip == 8'h00) begin
                    ce.cmd = 4'(kind); ce.addr = (kind >= 3) ? addr : 32'h0; ce.c = c;
                    cmd_q.push_back(ce);
                    tx_q.push_back(8'h5A);
                end else begin
                    ee.kind = 1; ee.c = c; err_q.push_back(ee);
                    tx_q.push_back(8'hEE);
                end
            end
        end
        if (stopped) begin
            ee.kind = 2; ee.c = last_c + TO; err_q.push_back(ee);
        end
        if (junk && !stopped) send_byte(8'hA5, c);
        if (do_wait) wait_idle();
    endtask

    // tx_ready driver: random acceptance unless the stimulus holds it low.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        pl_t pe;
        cmd_t ce;
        err_t ee;
        logic [7:0] te;
        forever begin
            @(negedge clk);
            if (pl_valid === 1'b1) begin
                if (pl_q.size() == 0) check("pl_unexpected", pl_valid, 1'b0);
                else begin
                    pe = pl_q.pop_front();
                    check("pl_data", pl_data, pe.data);
                    check("pl_last", pl_last, pe.last);
                    check("pl_cycle", cyc, pe.c);
                end
            end
            if (cmd_valid === 1'b1) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", cmd_valid, 1'b0);
                else begin
                    ce = cmd_q.pop_front();
                    check("host_cmd", host_cmd, ce.cmd);
                    check("cmd_addr", cmd_addr, ce.addr);
                    check("cmd_cycle", cyc, ce.c);
                end
            end
            if ((err_chk | err_timeout | err_cmd) === 1'b1) begin
                if (err_q.size() == 0) check("err_unexpected", {err_chk, err_timeout, err_cmd}, 3'b000);
                else begin
                    ee = err_q.pop_front();
                    check("err_kind", {err_chk, err_timeout, err_cmd},
                          (ee.kind == 1) ? 3'b100 : (ee.kind == 2) ? 3'b010 : 3'b001);
                    check("err_cycle", cyc, ee.c);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (tx_q.size() == 0) check("tx_unexpected", tx_valid, 1'b0);
                else begin
                    te = tx_q.pop_front();
                    check("tx_data", tx_data, te);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        apply_reset();

        run_frame(8'h50, 32'h0, 32'h0, 8'h00, -1, 0, 1'b0, 1'b1);
        run_frame(8'h20, 32'h00000100, 32'h0, 8'h00, -1, 0, 1'b0, 1'b1);
        run_frame(8'h40, 32'h00000008, 32'hDEADBEEF, 8'h00, -1, 0, 1'b0, 1'b1);
        run_frame(8'h40, 32'h00000008, 32'hDEADBEEF, 8'h01, -1, 0, 1'b0, 1'b1);
        run_frame(8'h10, 32'h0, 32'h0, 8'h00, -1, TO - 1, 1'b1, 1'b1);

        // Unknown command: NAK must stay presented while tx_ready is low.
        hold_ready = 1'b1;
        idle(1);
        run_frame(8'h77, 32'h0, 32'h0, 8'h00, -1, 0, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("nak_held_valid", tx_valid, 1'b1);
            check("nak_held_data", tx_data, 8'hEE);
        end
        @(posedge clk); #1;
        hold_ready = 1'b0;
        wait_idle();

        run_frame(8'h20, 32'h0, 32'h0, 8'h00, 2, 0, 1'b0, 1'b1);

        // Reset mid-frame, then a good frame.
        send_byte(8'hA5, c); send_byte(8'h20, c); send_byte(8'h00, c);
        idle(3);
        apply_reset();
        run_frame(8'h20, 32'h12345678, 32'h0, 8'h00, -1, 0, 1'b0, 1'b1);

        // Reset mid-response: the pending NAK is never delivered.
        hold_ready = 1'b1;
        send_byte(8'hA5, c);
        send_byte(8'h33, c);
        begin
            err_t ee;
            ee.kind = 3; ee.c = c; err_q.push_back(ee);
        end
        idle(3);
        apply_reset();
        hold_ready = 1'b0;
        run_frame(8'h50, 32'h0, 32'h0, 8'h00, -1, 0, 1'b0, 1'b1);

        for (int f = 0; f < 60; f++) begin
            logic [7:0] cmd, flip, n;
            int sel, kind, len, stop;
            bit junk;
            sel = $urandom_range(0, 4);
            case (sel)
                0: cmd = 8'h10;
                1: cmd = 8'h50;
                2: cmd = 8'h20;
                3: cmd = 8'h40;
                default: begin
                    cmd = 8'($urandom_range(0, 255));
                    while (cmd_kind(cmd) != 0) cmd = 8'($urandom_range(0, 255));
                end
            endcase
            kind = cmd_kind(cmd);
            len  = (kind == 0) ? 2 : 3 + ((kind >= 3) ? AB : 0) + ((kind == 4) ? PB : 0);
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            junk = (stop < 0) && ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 2)) begin
                n = 8'($urandom_range(0, 255));
                if (n == 8'hA5) n = 8'h00;
                send_byte(n, c);
                idle($urandom_range(0, 3));
            end
            run_frame(cmd, $urandom, $urandom, flip, stop, -1, junk, 1'b1);
        end

        idle(10);
        check("pl_q_drained", pl_q.size(), 0);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_cmd_parser.md
Name: host_cmd_parser

Overview:
Parametrised successor to the host UART command FSM. It parses framed host commands from the UART RX byte stream and streams WRITE payload bytes to the datapath. It issues a decoded command strobe with address to the SD command engine and returns an ACK/NAK byte to the UART TX. It adds address/payload fields, XOR checksum, inter-byte timeout and error reporting.

Parameters:
ADDR_BYTES, 4, address bytes in READ/WRITE frames (1..4), MSB first
PAYLOAD_BYTES, 4, WRITE payload bytes per frame (>=1)
TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame (>=2)
START_BYTE, 8'hA5, frame start marker
ACK_BYTE, 8'h5A, response on good frame
NAK_BYTE, 8'hEE, response on bad checksum or unknown command

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte, valid when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte (no backpressure)
tx_data  out  8  response byte
tx_valid  out  1  response valid; held until tx_ready
tx_ready  in  1  UART TX accepts byte when tx_valid&tx_ready
host_cmd  out  4  decoded command: 0 none, 1 INIT, 2 STATUS, 3 READ, 4 WRITE
cmd_addr  out  8*ADDR_BYTES  frame address (0 for INIT/STATUS)
cmd_valid  out  1  one-cycle strobe, good frame complete
pl_data  out  8  WRITE payload byte
pl_valid  out  1  one-cycle strobe per payload byte
pl_last  out  1  with pl_valid on final payload byte
err_chk  out  1  one-cycle pulse, checksum mismatch
err_timeout  out  1  one-cycle pulse, inter-byte timeout
err_cmd  out  1  one-cycle pulse, unknown command byte
busy  out  1  high in any state other than IDLE

Behaviour:
- Frame: START, CMD, [ADDR x ADDR_BYTES for READ/WRITE], [payload x PAYLOAD_BYTES for WRITE], CHK. CHK = XOR of all bytes from CMD through last byte before CHK.
- CMD codes: 8'h10 INIT, 8'h50 STATUS, 8'h20 READ, 8'h40 WRITE; others are unknown.
- Reset: state IDLE; all outputs 0 (tx_data, host_cmd, cmd_addr, pl_data included); counters, checksum accumulator and timer cleared. Reset mid-frame or mid-response aborts with no strobes or pulses.
- FSM: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, SEND_RESP.
- IDLE: rx byte == START_BYTE -> GET_CMD; other bytes are ignored.
- GET_CMD: INIT/STATUS -> GET_CHK; READ -> GET_ADDR; WRITE -> GET_ADDR; unknown -> err_cmd pulse, tx NAK, SEND_RESP. Accumulator is loaded with CMD.
- GET_ADDR: shift ADDR_BYTES bytes MSB first into the address register. After the last byte: READ -> GET_CHK, WRITE -> GET_DATA.
- GET_DATA: each byte emits pl_valid with pl_data = byte, 1 cycle after rx_valid. pl_last is set on byte PAYLOAD_BYTES. Then -> GET_CHK. Payload is forwarded before the checksum is known; the consumer discards it on err_chk.
- GET_CHK: match -> cmd_valid, host_cmd, cmd_addr registered 1 cycle after CHK rx_valid, tx ACK. Mismatch -> err_chk pulse, tx NAK, host_cmd stays 0. Both paths -> SEND_RESP.
- host_cmd/cmd_addr hold their value until the next cmd_valid or reset.
- SEND_RESP: tx_valid=1, tx_data stable until tx_ready; then -> IDLE. rx bytes arriving in SEND_RESP are dropped.
- Timeout: timer clears on every rx_valid and counts in GET_CMD..GET_CHK. At TIMEOUT_CYCLES with no byte: err_timeout pulse, -> IDLE, no response. If rx_valid coincides with expiry, the byte wins and the timer resets.
- In-frame START_BYTE value has no special meaning; no resync mid-frame.
- Address and payload counters use clog2-sized widths with no wrap beyond the parameter counts.
- Only one error pulse per frame.

Test Plan:
- ADDR_BYTES=4: A5 50 50 -> cmd_valid once, host_cmd=2, cmd_addr=0, tx 5A after tx_ready.
- A5 20 00 00 01 00 21 -> host_cmd=3, cmd_addr=32'h00000100, tx 5A.
- A5 40 00 00 00 08 DE AD BE EF CHK=40^08^DE^AD^BE^EF -> 4 pl_valid bytes DE,AD,BE,EF with pl_last on EF; cmd_valid host_cmd=4 addr=8; ACK.
- Same WRITE frame with CHK off by 1 -> payload still streamed, err_chk pulse, no cmd_valid, tx EE.
- A5 77 -> err_cmd, tx EE held 5 cycles with tx_ready=0 then accepted; then IDLE.
- A5 20 00, then silence TIMEOUT_CYCLES -> err_timeout, busy=0, no tx. Repeat with reset asserted mid-frame -> all outputs 0, next good frame parses normally.
